// File: rtl/cache_bus_arbiter.sv
// cache_bus_arbiter: whole-transaction arbiter sharing one simplified-AXI master port
// between the instruction cache and the data cache, with a sticky watchdog abort.
`default_nettype none

module cache_bus_arbiter #(
  parameter int RR_EN          = 1,
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int TO_W           = 11
) (
  input  logic        clk,
  input  logic        rst,
  // instruction-side requester
  input  logic [31:0] i_addr,
  input  logic        i_addr_valid,
  input  logic        i_we,
  input  logic [2:0]  i_size,
  input  logic [7:0]  i_lens,
  input  logic        i_rd_rready,
  input  logic [31:0] i_wr_data,
  input  logic        i_wr_dready,
  input  logic [3:0]  i_byte_enable,
  input  logic        i_wr_last,
  input  logic        i_response_rready,
  output logic        i_rd_dready,
  output logic        i_rd_last,
  output logic        i_rd_addr_clear,
  output logic        i_wr_next,
  output logic        i_wr_ok,
  output logic        i_wr_addr_clear,
  output logic [31:0] i_rd_data,
  // data-side requester
  input  logic [31:0] d_addr,
  input  logic        d_addr_valid,
  input  logic        d_we,
  input  logic [2:0]  d_size,
  input  logic [7:0]  d_lens,
  input  logic        d_rd_rready,
  input  logic [31:0] d_wr_data,
  input  logic        d_wr_dready,
  input  logic [3:0]  d_byte_enable,
  input  logic        d_wr_last,
  input  logic        d_response_rready,
  output logic        d_rd_dready,
  output logic        d_rd_last,
  output logic        d_rd_addr_clear,
  output logic        d_wr_next,
  output logic        d_wr_ok,
  output logic        d_wr_addr_clear,
  output logic [31:0] d_rd_data,
  // bus side
  output logic [31:0] AXI_addr,
  output logic        AXI_addr_valid,
  output logic        AXI_we,
  output logic [2:0]  AXI_size,
  output logic [7:0]  AXI_lens,
  output logic        AXI_rd_rready,
  output logic [31:0] AXI_wr_data,
  output logic        AXI_wr_dready,
  output logic [3:0]  AXI_byte_enable,
  output logic        AXI_wr_last,
  output logic        AXI_response_rready,
  input  logic        AXI_rd_dready,
  input  logic        AXI_rd_last,
  input  logic [31:0] AXI_rd_data,
  input  logic        AXI_rd_addr_clear,
  input  logic        AXI_wr_next,
  input  logic        AXI_wr_ok,
  input  logic        AXI_wr_addr_clear,
  output logic        bus_timeout,
  output logic        grant_d
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY_RD = 2'd1,
    BUSY_WR = 2'd2
  } state_t;

  localparam logic [TO_W-1:0] c_wd_limit   = TO_W'(TIMEOUT_CYCLES - 1);
  localparam logic            c_fixed_prio = (RR_EN == 0);

  state_t          r_state;
  logic            r_owner;
  logic            r_last_grant;
  logic            r_bus_timeout;
  logic            r_grant_d;
  logic [TO_W-1:0] r_wd;

  logic w_busy, w_sel_i, w_sel_d;
  logic w_pick_d, w_pick_we, w_done, w_event;

  assign w_busy  = (r_state != IDLE);
  assign w_sel_d = w_busy & r_owner;
  assign w_sel_i = w_busy & ~r_owner;

  // On a tie the side that did not own the bus last wins, unless data has fixed priority.
  assign w_pick_d  = d_addr_valid & (~i_addr_valid | c_fixed_prio | ~r_last_grant);
  assign w_pick_we = w_pick_d ? d_we : i_we;

  assign w_done = (r_state == BUSY_RD)
                ? (AXI_rd_dready & AXI_rd_last & (r_owner ? d_rd_rready : i_rd_rready))
                : (AXI_wr_ok & (r_owner ? d_response_rready : i_response_rready));
  assign w_event = AXI_rd_dready | AXI_rd_addr_clear | AXI_wr_next | AXI_wr_ok | AXI_wr_addr_clear;

  assign AXI_addr            = w_busy ? (r_owner ? d_addr            : i_addr)            : '0;
  assign AXI_addr_valid      = w_busy ? (r_owner ? d_addr_valid      : i_addr_valid)      : 1'b0;
  assign AXI_we              = w_busy ? (r_owner ? d_we              : i_we)              : 1'b0;
  assign AXI_size            = w_busy ? (r_owner ? d_size            : i_size)            : '0;
  assign AXI_lens            = w_busy ? (r_owner ? d_lens            : i_lens)            : '0;
  assign AXI_rd_rready       = w_busy ? (r_owner ? d_rd_rready       : i_rd_rready)       : 1'b0;
  assign AXI_wr_data         = w_busy ? (r_owner ? d_wr_data         : i_wr_data)         : '0;
  assign AXI_wr_dready       = w_busy ? (r_owner ? d_wr_dready       : i_wr_dready)       : 1'b0;
  assign AXI_byte_enable     = w_busy ? (r_owner ? d_byte_enable     : i_byte_enable)     : '0;
  assign AXI_wr_last         = w_busy ? (r_owner ? d_wr_last         : i_wr_last)         : 1'b0;
  assign AXI_response_rready = w_busy ? (r_owner ? d_response_rready : i_response_rready) : 1'b0;

  assign i_rd_dready     = w_sel_i & AXI_rd_dready;
  assign i_rd_last       = w_sel_i & AXI_rd_last;
  assign i_rd_addr_clear = w_sel_i & AXI_rd_addr_clear;
  assign i_wr_next       = w_sel_i & AXI_wr_next;
  assign i_wr_ok         = w_sel_i & AXI_wr_ok;
  assign i_wr_addr_clear = w_sel_i & AXI_wr_addr_clear;
  assign i_rd_data       = w_sel_i ? AXI_rd_data : '0;

  assign d_rd_dready     = w_sel_d & AXI_rd_dready;
  assign d_rd_last       = w_sel_d & AXI_rd_last;
  assign d_rd_addr_clear = w_sel_d & AXI_rd_addr_clear;
  assign d_wr_next       = w_sel_d & AXI_wr_next;
  assign d_wr_ok         = w_sel_d & AXI_wr_ok;
  assign d_wr_addr_clear = w_sel_d & AXI_wr_addr_clear;
  assign d_rd_data       = w_sel_d ? AXI_rd_data : '0;

  assign bus_timeout = r_bus_timeout;
  assign grant_d     = r_grant_d;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state       <= IDLE;
      r_owner       <= 1'b0;
      r_last_grant  <= 1'b0;
      r_bus_timeout <= 1'b0;
      r_grant_d     <= 1'b0;
      r_wd          <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (i_addr_valid | d_addr_valid) begin
            r_owner   <= w_pick_d;
            r_grant_d <= w_pick_d;
            r_wd      <= '0;
            r_state   <= w_pick_we ? BUSY_WR : BUSY_RD;
          end
        end
        BUSY_RD, BUSY_WR: begin
          // A completion on the watchdog's last cycle still counts as a normal end.
          if (w_done) begin
            r_state      <= IDLE;
            r_last_grant <= r_owner;
          end else if (w_event) begin
            r_wd <= '0;
          end else if (r_wd == c_wd_limit) begin
            r_state       <= IDLE;
            r_bus_timeout <= 1'b1;
            r_last_grant  <= r_owner;
          end else begin
            r_wd <= r_wd + TO_W'(1);
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_cache_bus_arbiter.sv
// tb_cache_bus_arbiter: table vectors, directed corner sequences and a randomized run
// checked against a transaction-level model of the arbiter.
`default_nettype none

module tb_cache_bus_arbiter;

  localparam int RR = 1;
  localparam int TO = 16;
  localparam logic [31:0] IA = 32'h1000_0000;
  localparam logic [31:0] DA = 32'h2000_0000;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [31:0] i_addr, d_addr, i_wr_data, d_wr_data, AXI_rd_data;
  logic        i_addr_valid, d_addr_valid, i_we, d_we;
  logic [2:0]  i_size, d_size;
  logic [7:0]  i_lens, d_lens;
  logic        i_rd_rready, d_rd_rready, i_wr_dready, d_wr_dready;
  logic [3:0]  i_byte_enable, d_byte_enable;
  logic        i_wr_last, d_wr_last, i_response_rready, d_response_rready;
  logic        AXI_rd_dready, AXI_rd_last, AXI_rd_addr_clear, AXI_wr_next, AXI_wr_ok, AXI_wr_addr_clear;

  // outputs of the round-robin instance (a_) and the data-priority instance (b_)
  logic        a_i_rd_dready, a_i_rd_last, a_i_rd_addr_clear, a_i_wr_next, a_i_wr_ok, a_i_wr_addr_clear;
  logic        a_d_rd_dready, a_d_rd_last, a_d_rd_addr_clear, a_d_wr_next, a_d_wr_ok, a_d_wr_addr_clear;
  logic [31:0] a_i_rd_data, a_d_rd_data, a_AXI_addr, a_AXI_wr_data;
  logic        a_AXI_addr_valid, a_AXI_we, a_AXI_rd_rready, a_AXI_wr_dready, a_AXI_wr_last, a_AXI_response_rready;
  logic [2:0]  a_AXI_size;
  logic [7:0]  a_AXI_lens;
  logic [3:0]  a_AXI_byte_enable;
  logic        a_bus_timeout, a_grant_d;

  logic        b_i_rd_dready, b_i_rd_last, b_i_rd_addr_clear, b_i_wr_next, b_i_wr_ok, b_i_wr_addr_clear;
  logic        b_d_rd_dready, b_d_rd_last, b_d_rd_addr_clear, b_d_wr_next, b_d_wr_ok, b_d_wr_addr_clear;
  logic [31:0] b_i_rd_data, b_d_rd_data, b_AXI_addr, b_AXI_wr_data;
  logic        b_AXI_addr_valid, b_AXI_we, b_AXI_rd_rready, b_AXI_wr_dready, b_AXI_wr_last, b_AXI_response_rready;
  logic [2:0]  b_AXI_size;
  logic [7:0]  b_AXI_lens;
  logic [3:0]  b_AXI_byte_enable;
  logic        b_bus_timeout, b_grant_d;

  cache_bus_arbiter #(.RR_EN(1), .TIMEOUT_CYCLES(TO), .TO_W(5)) u_rr (
    .clk(clk), .rst(rst),
    .i_addr(i_addr), .i_addr_valid(i_addr_valid), .i_we(i_we), .i_size(i_size), .i_lens(i_lens),
    .i_rd_rready(i_rd_rready), .i_wr_data(i_wr_data), .i_wr_dready(i_wr_dready),
    .i_byte_enable(i_byte_enable), .i_wr_last(i_wr_last), .i_response_rready(i_response_rready),
    .i_rd_dready(a_i_rd_dready), .i_rd_last(a_i_rd_last), .i_rd_addr_clear(a_i_rd_addr_clear),
    .i_wr_next(a_i_wr_next), .i_wr_ok(a_i_wr_ok), .i_wr_addr_clear(a_i_wr_addr_clear), .i_rd_data(a_i_rd_data),
    .d_addr(d_addr), .d_addr_valid(d_addr_valid), .d_we(d_we), .d_size(d_size), .d_lens(d_lens),
    .d_rd_rready(d_rd_rready), .d_wr_data(d_wr_data), .d_wr_dready(d_wr_dready),
    .d_byte_enable(d_byte_enable), .d_wr_last(d_wr_last), .d_response_rready(d_response_rready),
    .d_rd_dready(a_d_rd_dready), .d_rd_last(a_d_rd_last), .d_rd_addr_clear(a_d_rd_addr_clear),
    .d_wr_next(a_d_wr_next), .d_wr_ok(a_d_wr_ok), .d_wr_addr_clear(a_d_wr_addr_clear), .d_rd_data(a_d_rd_data),
    .AXI_addr(a_AXI_addr), .AXI_addr_valid(a_AXI_addr_valid), .AXI_we(a_AXI_we), .AXI_size(a_AXI_size),
    .AXI_lens(a_AXI_lens), .AXI_rd_rready(a_AXI_rd_rready), .AXI_wr_data(a_AXI_wr_data),
    .AXI_wr_dready(a_AXI_wr_dready), .AXI_byte_enable(a_AXI_byte_enable), .AXI_wr_last(a_AXI_wr_last),
    .AXI_response_rready(a_AXI_response_rready),
    .AXI_rd_dready(AXI_rd_dready), .AXI_rd_last(AXI_rd_last), .AXI_rd_data(AXI_rd_data),
    .AXI_rd_addr_clear(AXI_rd_addr_clear), .AXI_wr_next(AXI_wr_next), .AXI_wr_ok(AXI_wr_ok),
    .AXI_wr_addr_clear(AXI_wr_addr_clear), .bus_timeout(a_bus_timeout), .grant_d(a_grant_d)
  );

  cache_bus_arbiter #(.RR_EN(0), .TIMEOUT_CYCLES(TO), .TO_W(5)) u_fp (
    .clk(clk), .rst(rst),
    .i_addr(i_addr), .i_addr_valid(i_addr_valid), .i_we(i_we), .i_size(i_size), .i_lens(i_lens),
    .i_rd_rready(i_rd_rready), .i_wr_data(i_wr_data), .i_wr_dready(i_wr_dready),
    .i_byte_enable(i_byte_enable), .i_wr_last(i_wr_last), .i_response_rready(i_response_rready),
    .i_rd_dready(b_i_rd_dready), .i_rd_last(b_i_rd_last), .i_rd_addr_clear(b_i_rd_addr_clear),
    .i_wr_next(b_i_wr_next), .i_wr_ok(b_i_wr_ok), .i_wr_addr_clear(b_i_wr_addr_clear), .i_rd_data(b_i_rd_data),
    .d_addr(d_addr), .d_addr_valid(d_addr_valid), .d_we(d_we), .d_size(d_size), .d_lens(d_lens),
    .d_rd_rready(d_rd_rready), .d_wr_data(d_wr_data), .d_wr_dready(d_wr_dready),
    .d_byte_enable(d_byte_enable), .d_wr_last(d_wr_last), .d_response_rready(d_response_rready),
    .d_rd_dready(b_d_rd_dready), .d_rd_last(b_d_rd_last), .d_rd_addr_clear(b_d_rd_addr_clear),
    .d_wr_next(b_d_wr_next), .d_wr_ok(b_d_wr_ok), .d_wr_addr_clear(b_d_wr_addr_clear), .d_rd_data(b_d_rd_data),
    .AXI_addr(b_AXI_addr), .AXI_addr_valid(b_AXI_addr_valid), .AXI_we(b_AXI_we), .AXI_size(b_AXI_size),
    .AXI_lens(b_AXI_lens), .AXI_rd_rready(b_AXI_rd_rready), .AXI_wr_data(b_AXI_wr_data),
    .AXI_wr_dready(b_AXI_wr_dready), .AXI_byte_enable(b_AXI_byte_enable), .AXI_wr_last(b_AXI_wr_last),
    .AXI_response_rready(b_AXI_response_rready),
    .AXI_rd_dready(AXI_rd_dready), .AXI_rd_last(AXI_rd_last), .AXI_rd_data(AXI_rd_data),
    .AXI_rd_addr_clear(AXI_rd_addr_clear), .AXI_wr_next(AXI_wr_next), .AXI_wr_ok(AXI_wr_ok),
    .AXI_wr_addr_clear(AXI_wr_addr_clear), .bus_timeout(b_bus_timeout), .grant_d(b_grant_d)
  );

  int n_pass  = 0;
  int n_total = 0;

  // transaction-level model of the round-robin instance
  logic m_busy, m_own, m_wr, m_last, m_to, m_gd;
  int   m_silent;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  task automatic model_step();
    logic done, ev;
    if (!rst) begin
      m_busy = 0; m_own = 0; m_wr = 0; m_last = 0; m_to = 0; m_gd = 0; m_silent = 0;
    end else if (!m_busy) begin
      if (i_addr_valid || d_addr_valid) begin
        if (i_addr_valid && d_addr_valid) m_own = (RR != 0) ? !m_last : 1'b1;
        else m_own = d_addr_valid;
        m_gd = m_own; m_busy = 1; m_silent = 0;
        m_wr = m_own ? d_we : i_we;
      end
    end else begin
      done = m_wr ? (AXI_wr_ok && (m_own ? d_response_rready : i_response_rready))
                  : (AXI_rd_dready && AXI_rd_last && (m_own ? d_rd_rready : i_rd_rready));
      ev = AXI_rd_dready || AXI_rd_addr_clear || AXI_wr_next || AXI_wr_ok || AXI_wr_addr_clear;
      if (done) begin
        m_busy = 0; m_last = m_own;
      end else if (ev) begin
        m_silent = 0;
      end else begin
        m_silent++;
        if (m_silent == TO) begin m_busy = 0; m_to = 1; m_last = m_own; end
      end
    end
  endtask

  task automatic cyc();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    i_addr = IA; d_addr = DA; i_wr_data = '0; d_wr_data = '0; AXI_rd_data = '0;
    i_addr_valid = 0; d_addr_valid = 0; i_we = 0; d_we = 0;
    i_size = 3'd2; d_size = 3'd2; i_lens = '0; d_lens = '0;
    i_rd_rready = 1; d_rd_rready = 1; i_wr_dready = 0; d_wr_dready = 0;
    i_byte_enable = '0; d_byte_enable = '0; i_wr_last = 0; d_wr_last = 0;
    i_response_rready = 1; d_response_rready = 1;
    AXI_rd_dready = 0; AXI_rd_last = 0; AXI_rd_addr_clear = 0;
    AXI_wr_next = 0; AXI_wr_ok = 0; AXI_wr_addr_clear = 0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst = 0;
    cyc();
    rst = 1;
  endtask

  task automatic rd_complete();
    AXI_rd_dready = 1; AXI_rd_last = 1;
    cyc();
    AXI_rd_dready = 0; AXI_rd_last = 0;
  endtask

  typedef struct {
    logic iv, dv, iwe, dwe;
    logic        exp_av, exp_gd, exp_we;
    logic [31:0] exp_addr;
  } vec_t;

  vec_t tbl[6];

  initial begin
    tbl[0] = '{0, 0, 0, 0, 0, 0, 0, 32'h0};
    tbl[1] = '{1, 0, 0, 0, 1, 0, 0, IA};
    tbl[2] = '{0, 1, 0, 1, 1, 1, 1, DA};
    tbl[3] = '{1, 1, 1, 0, 1, 1, 0, DA};
    tbl[4] = '{1, 0, 1, 0, 1, 0, 1, IA};
    tbl[5] = '{1, 1, 0, 1, 1, 1, 1, DA};

    // reset state, with bus returns active to show they are blocked
    do_reset();
    AXI_rd_data = 32'hDEAD_BEEF; AXI_rd_dready = 1; AXI_wr_ok = 1;
    #1;
    chk("reset grant_d", a_grant_d, 0);
    chk("reset bus_timeout", a_bus_timeout, 0);
    chk("reset AXI_addr_valid", a_AXI_addr_valid, 0);
    chk("reset d_rd_data", a_d_rd_data, 0);
    chk("reset i_wr_ok", a_i_wr_ok, 0);

    // single-edge arbitration from reset (last_grant = 0)
    for (int k = 0; k < 6; k++) begin
      do_reset();
      i_addr_valid = tbl[k].iv; d_addr_valid = tbl[k].dv; i_we = tbl[k].iwe; d_we = tbl[k].dwe;
      cyc();
      chk($sformatf("vec%0d addr_valid", k), a_AXI_addr_valid, tbl[k].exp_av);
      chk($sformatf("vec%0d grant_d", k), a_grant_d, tbl[k].exp_gd);
      chk($sformatf("vec%0d AXI_we", k), a_AXI_we, tbl[k].exp_we);
      chk($sformatf("vec%0d AXI_addr", k), a_AXI_addr, tbl[k].exp_addr);
      chk($sformatf("vec%0d fp AXI_addr", k), b_AXI_addr, tbl[k].exp_addr);
    end

    // data read burst of 4 beats
    do_reset();
    d_addr_valid = 1; d_lens = 8'd3;
    cyc();
    chk("rd1 addr_valid", a_AXI_addr_valid, 1);
    chk("rd1 addr", a_AXI_addr, DA);
    chk("rd1 lens", a_AXI_lens, 3);
    d_addr_valid = 0;
    for (int k = 0; k < 4; k++) begin
      AXI_rd_dready = 1; AXI_rd_data = 32'hA0 + k; AXI_rd_last = (k == 3);
      #1;
      chk("rd1 d_rd_data", a_d_rd_data, 32'hA0 + k);
      chk("rd1 i_rd_dready", a_i_rd_dready, 0);
      chk("rd1 i_rd_data", a_i_rd_data, 0);
      cyc();
    end
    #1;
    chk("rd1 idle addr", a_AXI_addr, 0);
    chk("rd1 idle d_rd_dready", a_d_rd_dready, 0);
    AXI_rd_dready = 0; AXI_rd_last = 0;

    // both requesting continuously: alternate on u_rr, data always on u_fp
    do_reset();
    i_addr_valid = 1; d_addr_valid = 1;
    cyc();
    chk("rr first grant_d", a_grant_d, 1);
    chk("fp first grant_d", b_grant_d, 1);
    for (int r = 0; r < 3; r++) begin
      rd_complete();
      #1;
      chk("rr idle gap addr", a_AXI_addr, 0);
      cyc();
      chk("rr alternate grant_d", a_grant_d, (r % 2 == 0) ? 1'b0 : 1'b1);
      chk("rr alternate addr", a_AXI_addr, (r % 2 == 0) ? IA : DA);
      chk("fp grant_d", b_grant_d, 1);
      chk("fp addr", b_AXI_addr, DA);
    end

    // data write burst of 8 beats with an instruction read pending
    do_reset();
    d_addr_valid = 1; d_we = 1; d_lens = 8'd7; i_addr_valid = 1;
    cyc();
    chk("wr grant_d", a_grant_d, 1);
    chk("wr AXI_we", a_AXI_we, 1);
    chk("wr lens", a_AXI_lens, 7);
    for (int k = 0; k < 8; k++) begin
      AXI_wr_next = 1; d_wr_data = 32'h5500 + k;
      #1;
      chk("wr d_wr_next", a_d_wr_next, 1);
      chk("wr i_wr_next", a_i_wr_next, 0);
      chk("wr data", a_AXI_wr_data, 32'h5500 + k);
      cyc();
    end
    AXI_wr_next = 0; AXI_wr_ok = 1;
    #1;
    chk("wr d_wr_ok", a_d_wr_ok, 1);
    chk("wr i_wr_ok", a_i_wr_ok, 0);
    cyc();
    AXI_wr_ok = 0; d_addr_valid = 0;
    #1;
    chk("wr idle addr", a_AXI_addr, 0);
    cyc();
    chk("wr pending inst grant_d", a_grant_d, 0);
    chk("wr pending inst addr", a_AXI_addr, IA);
    i_addr_valid = 0;
    rd_complete();

    // a handshake pulse restarts the watchdog; completion on the limit cycle is normal
    do_reset();
    i_addr_valid = 1;
    cyc();
    i_addr_valid = 0;
    for (int k = 0; k < 10; k++) cyc();
    AXI_rd_addr_clear = 1;
    cyc();
    AXI_rd_addr_clear = 0;
    for (int k = 0; k < 10; k++) cyc();
    chk("wd restart still busy", a_AXI_addr, IA);
    for (int k = 0; k < TO - 11; k++) cyc();
    AXI_rd_dready = 1; AXI_rd_last = 1;
    cyc();
    AXI_rd_dready = 0; AXI_rd_last = 0;
    #1;
    chk("wd limit completion idle", a_AXI_addr, 0);
    chk("wd limit completion no timeout", a_bus_timeout, 0);

    // watchdog abort after TO silent cycles, sticky until reset
    do_reset();
    i_addr_valid = 1;
    cyc();
    i_addr_valid = 0;
    for (int k = 0; k < TO - 1; k++) cyc();
    chk("wd pre-limit busy", a_AXI_addr, IA);
    chk("wd pre-limit flag", a_bus_timeout, 0);
    cyc();
    chk("wd abort idle", a_AXI_addr, 0);
    chk("wd abort flag", a_bus_timeout, 1);
    d_addr_valid = 1;
    cyc();
    d_addr_valid = 0;
    chk("wd later grant", a_grant_d, 1);
    rd_complete();
    chk("wd flag sticky", a_bus_timeout, 1);
    rst = 0;
    cyc();
    rst = 1;
    chk("wd flag cleared by reset", a_bus_timeout, 0);

    // reset mid burst
    do_reset();
    d_addr_valid = 1; d_lens = 8'd3;
    cyc();
    AXI_rd_dready = 1; AXI_rd_data = 32'h77;
    cyc();
    rst = 0;
    cyc();
    chk("midrst addr", a_AXI_addr, 0);
    chk("midrst d_rd_dready", a_d_rd_dready, 0);
    chk("midrst d_rd_data", a_d_rd_data, 0);
    chk("midrst grant_d", a_grant_d, 0);
    rst = 1; AXI_rd_dready = 0; d_addr_valid = 0; i_addr_valid = 1;
    cyc();
    chk("midrst new grant addr", a_AXI_addr, IA);
    chk("midrst new grant_d", a_grant_d, 0);

    // randomized traffic against the model
    do_reset();
    for (int c = 0; c < 2500; c++) begin
      logic quiet;
      quiet = ((c / 200) % 4 == 3);
      rst = ($urandom % 400) != 0;
      i_addr_valid = ($urandom % 3) == 0;
      d_addr_valid = ($urandom % 3) == 0;
      i_we = $urandom % 2; d_we = $urandom % 2;
      i_addr = $urandom; d_addr = $urandom;
      i_rd_rready = ($urandom % 4) != 0; d_rd_rready = ($urandom % 4) != 0;
      i_response_rready = ($urandom % 4) != 0; d_response_rready = ($urandom % 4) != 0;
      AXI_rd_data = $urandom;
      AXI_rd_dready = !quiet && (($urandom % 5) == 0);
      AXI_rd_last = ($urandom % 3) == 0;
      AXI_rd_addr_clear = !quiet && (($urandom % 12) == 0);
      AXI_wr_next = !quiet && (($urandom % 6) == 0);
      AXI_wr_ok = !quiet && (($urandom % 6) == 0);
      AXI_wr_addr_clear = !quiet && (($urandom % 12) == 0);
      #1;
      chk("rand grant_d", a_grant_d, m_gd);
      chk("rand bus_timeout", a_bus_timeout, m_to);
      chk("rand AXI_addr", a_AXI_addr, m_busy ? (m_own ? d_addr : i_addr) : 32'h0);
      chk("rand AXI_we", a_AXI_we, m_busy ? (m_own ? d_we : i_we) : 1'b0);
      chk("rand d_rd_data", a_d_rd_data, (m_busy && m_own) ? AXI_rd_data : 32'h0);
      chk("rand i_rd_dready", a_i_rd_dready, (m_busy && !m_own) ? AXI_rd_dready : 1'b0);
      chk("rand i_wr_ok", a_i_wr_ok, (m_busy && !m_own) ? AXI_wr_ok : 1'b0);
      cyc();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/cache_bus_arbiter.md
Name: cache_bus_arbiter

Overview:
Shares the single simplified-AXI master port of the CPU between the instruction cache and the data-side cache/uncache block. It arbitrates whole transactions: once granted, a requester owns the bus until its burst completes. Downstream it connects to the AXI protocol bridge. It holds the bus ownership state, a round-robin pointer and a watchdog.

Parameters:
RR_EN, 1, 1 = round-robin on simultaneous requests; 0 = data side always wins.
TIMEOUT_CYCLES, 1024, busy cycles with no handshake event before the watchdog aborts the grant; must be ≥2.
TO_W, 11, watchdog counter width; must satisfy 2^TO_W > TIMEOUT_CYCLES.

Ports:
clk  in  1  clock
rst  in  1  reset; synchronous, active-low
i_addr / d_addr  in  32  requester address
i_addr_valid / d_addr_valid  in  1  requester bus request
i_we / d_we  in  1  1 = write transaction
i_size / d_size  in  3  requester size
i_lens / d_lens  in  8  requester burst length
i_rd_rready / d_rd_rready  in  1  requester ready to take read data
i_wr_data / d_wr_data  in  32  requester write data
i_wr_dready / d_wr_dready  in  1  requester write beat valid
i_byte_enable / d_byte_enable  in  4  requester write strobes
i_wr_last / d_wr_last  in  1  requester last write beat
i_response_rready / d_response_rready  in  1  requester ready for write response
i_rd_dready / d_rd_dready, i_rd_last / d_rd_last, i_rd_addr_clear / d_rd_addr_clear, i_wr_next / d_wr_next, i_wr_ok / d_wr_ok, i_wr_addr_clear / d_wr_addr_clear  out  1 each  return strobes to each requester
i_rd_data / d_rd_data  out  32  read data to each requester
AXI_addr, AXI_addr_valid, AXI_we, AXI_size, AXI_lens, AXI_rd_rready, AXI_wr_data, AXI_wr_dready, AXI_byte_enable, AXI_wr_last, AXI_response_rready  out  32/1/1/3/8/1/32/1/4/1/1  bus-side request signals
AXI_rd_dready, AXI_rd_last, AXI_rd_data, AXI_rd_addr_clear, AXI_wr_next, AXI_wr_ok, AXI_wr_addr_clear  in  1/1/32/1/1/1/1  bus-side returns
bus_timeout  out  1  sticky watchdog flag
grant_d  out  1  1 = data side currently owns the bus

Behaviour:
- States: IDLE, BUSY_RD, BUSY_WR. A registered owner bit (0 = inst, 1 = data) and a last_grant bit.
- Reset, sampled at posedge with rst == 0:
  - state = IDLE, owner = 0, last_grant = 0, watchdog = 0.
  - bus_timeout = 0, grant_d = 0.
  - All AXI_* outputs and all i_* / d_* outputs are 0.
- Reset mid-burst aborts the transaction with no handshake completion.
- IDLE:
  - All AXI_* outputs are 0; all return outputs are 0.
  - A request is seen when addr_valid = 1 at a posedge.
  - One request only: grant that requester.
  - Both requesting, RR_EN = 1: grant the side ≠ last_grant.
  - Both requesting, RR_EN = 0: grant data.
  - Next state is BUSY_WR if the granted side's we = 1, else BUSY_RD. owner and grant_d update on the same edge.
  - Grant latency: bus outputs carry the owner's signals starting the cycle after the request is first sampled.
- BUSY_*:
  - All AXI_* request outputs are combinationally muxed from the owner.
  - AXI return inputs are routed only to the owner's outputs. The non-owner sees 0 on all return strobes and 0 on rd_data.
  - The non-owner's request is held pending; it is not dropped.
- Completion:
  - BUSY_RD ends at a posedge with AXI_rd_dready & AXI_rd_last & owner rd_rready.
  - BUSY_WR ends at a posedge with AXI_wr_ok & owner response_rready.
  - On completion: next state IDLE, last_grant ← owner.
  - IDLE always lasts at least one cycle, so turnaround between transactions is ≥1 cycle.
- Owner deasserting addr_valid mid-transaction is not an end condition; only the completion handshakes end a grant.
- Watchdog:
  - Counter is cleared on entry to BUSY_* and on any cycle with a rd_dready, rd_addr_clear, wr_next, wr_ok or wr_addr_clear pulse.
  - Otherwise it increments while in BUSY_*.
  - When it reaches TIMEOUT_CYCLES-1 and no event is present: state → IDLE, bus_timeout ← 1 (sticky until reset), last_grant ← owner.
  - A completion event on the same cycle as the watchdog limit counts as a normal completion; no timeout is raised.
- grant_d holds its last value in IDLE.

Test Plan:
1. Single request: d read, lens=3, at cycle 0 → AXI_addr_valid=1 at cycle 1 with d_addr; 4 rd_dready beats reach d_rd_data only; i_rd_dready stays 0; IDLE one cycle after the beat carrying rd_last.
2. Simultaneous requests, RR_EN=1, after reset (last_grant=0) → data granted first; inst granted immediately after the 1 IDLE cycle. Repeat → order alternates inst, data.
3. RR_EN=0, both sides hold requests continuously → data wins every arbitration; inst is never granted while d_addr_valid=1 in IDLE.
4. d write burst lens=7 with inst read pending → 8 wr_next beats to d; completion on wr_ok & d_response_rready; inst granted 2 cycles later.
5. Grant, then bus silent for TIMEOUT_CYCLES=16 (override) → state IDLE on cycle 16; bus_timeout=1, and it stays 1 across further traffic until rst=0.
6. rst=0 asserted mid read burst → next cycle all outputs 0 and state IDLE; a new request after release is granted normally.
